// File: rtl/speed_counter_ctrl.sv
// Switch-selected up/down counter on a single clock, paced by prescaler clock-enables.
// Optional build macro SPEED_RAMP_EN steps the mode one code at a time with a dwell per step.
module speed_counter_ctrl #(
  parameter int CNT_W        = 4,
  parameter int DIV_SLOW     = 20,
  parameter int DIV_MED      = 2,
  parameter int DIV_FAST     = 1,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 4,
  parameter int RAMP_CYC     = 100
) (
  input  logic             clk_100mhz,
  input  logic             rst,
  input  logic [1:0]       sw,
  input  logic             dir,
  input  logic             clr,
  output logic [CNT_W-1:0] led,
  output logic             tick,
  output logic [1:0]       mode
);

  localparam int DMAX = (DIV_SLOW > DIV_MED) ?
                        ((DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST) :
                        ((DIV_MED  > DIV_FAST) ? DIV_MED  : DIV_FAST);
  localparam int PW   = (DMAX > 1) ? $clog2(DMAX) : 1;
  localparam int SCW  = $clog2(DEBOUNCE_CYC + 1);

  localparam logic [PW-1:0] SLOW_M1 = PW'(DIV_SLOW - 1);
  localparam logic [PW-1:0] MED_M1  = PW'(DIV_MED - 1);
  localparam logic [PW-1:0] FAST_M1 = PW'(DIV_FAST - 1);

  // sw, dir and clr share one synchroniser chain: {clr, dir, sw[1:0]}
  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [1:0]                  sw_sync;
  logic                        dir_sync, clr_sync;

  always_ff @(posedge clk_100mhz or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], {clr, dir, sw}};
  end

  assign sw_sync  = sync_q[SYNC_STAGES-1][1:0];
  assign dir_sync = sync_q[SYNC_STAGES-1][2];
  assign clr_sync = sync_q[SYNC_STAGES-1][3];

  // Debounce: the reload cycle already counts as the first stable cycle
  logic [1:0]     cand, target;
  logic [SCW-1:0] stab_cnt;

  always_ff @(posedge clk_100mhz or negedge rst) begin
    if (!rst) begin
      cand     <= '0;
      stab_cnt <= '0;
      target   <= '0;
    end else if (sw_sync != cand) begin
      cand     <= sw_sync;
      stab_cnt <= SCW'(1);
      if (DEBOUNCE_CYC == 1) target <= sw_sync;
    end else if (stab_cnt < SCW'(DEBOUNCE_CYC)) begin
      stab_cnt <= stab_cnt + 1'b1;
      if (stab_cnt == SCW'(DEBOUNCE_CYC - 1)) target <= cand;
    end
  end

  logic [1:0] mode_nxt;

`ifdef SPEED_RAMP_EN
  localparam int RW = $clog2(RAMP_CYC + 1);

  typedef enum logic {HOLD, RAMP} state_t;
  state_t        state, state_nxt;
  logic [RW-1:0] ramp_cnt, ramp_nxt;

  function automatic logic [1:0] step_to(input logic [1:0] cur, input logic [1:0] tgt);
    return (tgt > cur) ? cur + 2'd1 : cur - 2'd1;
  endfunction

  always_ff @(posedge clk_100mhz or negedge rst) begin
    if (!rst) begin
      state    <= HOLD;
      ramp_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ramp_cnt <= ramp_nxt;
    end
  end

  // A retarget mid-ramp keeps the dwell count; the next step heads to the new target
  always_comb begin
    state_nxt = state;
    mode_nxt  = mode;
    ramp_nxt  = ramp_cnt;
    case (state)
      HOLD: if (target != mode) begin
        mode_nxt  = step_to(mode, target);
        ramp_nxt  = '0;
        state_nxt = RAMP;
      end
      RAMP: if (mode == target) begin
        state_nxt = HOLD;
      end else if (ramp_cnt == RW'(RAMP_CYC - 1)) begin
        mode_nxt = step_to(mode, target);
        ramp_nxt = '0;
      end else begin
        ramp_nxt = ramp_cnt + 1'b1;
      end
      default: state_nxt = HOLD;
    endcase
  end
`else
  assign mode_nxt = target;
`endif

  always_ff @(posedge clk_100mhz or negedge rst) begin
    if (!rst) mode <= 2'b00;
    else      mode <= mode_nxt;
  end

  logic [PW-1:0] pre;
  logic          pre_hit;

  always_comb begin
    pre_hit = 1'b0;
    case (mode)
      2'b01:   pre_hit = (pre == SLOW_M1);
      2'b10:   pre_hit = (pre == MED_M1);
      2'b11:   pre_hit = (pre == FAST_M1);
      default: pre_hit = 1'b0;
    endcase
  end

  // Prescaler restarts on every mode change so the first tick lands DIV cycles later
  always_ff @(posedge clk_100mhz or negedge rst) begin
    if (!rst) begin
      pre  <= '0;
      led  <= '0;
      tick <= 1'b0;
    end else begin
      if (mode_nxt != mode || mode == 2'b00) pre <= '0;
      else if (pre_hit)                      pre <= '0;
      else                                   pre <= pre + 1'b1;

      if (clr_sync) begin
        led  <= '0;
        tick <= 1'b0;
      end else if (pre_hit) begin
        led  <= dir_sync ? led + CNT_W'(1) : led - CNT_W'(1);
        tick <= 1'b1;
      end else begin
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_speed_counter_ctrl.sv
// Scoreboard bench: stimulus pushes expected ticks and mode changes; a negedge monitor pops and compares.
module tb_speed_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] sw  = 2'b00;
  logic       dir = 1'b1;
  logic       clr = 1'b0;
  logic [3:0] led;
  logic       tick;
  logic [1:0] mode;

  speed_counter_ctrl dut (
    .clk_100mhz(clk), .rst(rst), .sw(sw), .dir(dir), .clr(clr),
    .led(led), .tick(tick), .mode(mode)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int led; int mode; } tick_t;
  typedef struct { int cyc; int mode; } mchg_t;

  tick_t tick_q[$];
  mchg_t mode_q[$];
  int    n_vec = 0, n_err = 0;
  int    cyc = 0;
  bit    chk_ticks = 1'b1;
  logic [1:0] mode_prev = 2'b00;

  // Edge count since reset release: after edge k, cyc == k
  always @(posedge clk) begin
    if (!rst) cyc = 0;
    else      cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      mode_prev = 2'b00;
    end else begin
      if (tick && chk_ticks) begin
        n_vec++;
        if (tick_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_tick: cyc=%0d led=%0d mode=%0d, none expected", cyc, led, mode);
        end else begin
          tick_t e;
          e = tick_q.pop_front();
          if (cyc != e.cyc || int'(led) != e.led || int'(mode) != e.mode) begin
            n_err++;
            $display("FAIL tick: got cyc=%0d led=%0d mode=%0d, expected cyc=%0d led=%0d mode=%0d",
                     cyc, led, mode, e.cyc, e.led, e.mode);
          end
        end
      end
      if (mode != mode_prev) begin
        n_vec++;
        if (mode_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_mode: cyc=%0d mode=%0d, none expected", cyc, mode);
        end else begin
          mchg_t m;
          m = mode_q.pop_front();
          if (cyc != m.cyc || int'(mode) != m.mode) begin
            n_err++;
            $display("FAIL mode_change: got cyc=%0d mode=%0d, expected cyc=%0d mode=%0d",
                     cyc, mode, m.cyc, m.mode);
          end
        end
      end
      mode_prev = mode;
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cyc=%0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic go(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_mode(input int c, input int md);
    mchg_t m;
    m.cyc = c; m.mode = md;
    mode_q.push_back(m);
  endtask

  task automatic push_ticks(input int first, input int period, input int count,
                            input int led0, input bit up, input int md);
    tick_t e;
    int    v;
    v = led0;
    for (int i = 0; i < count; i++) begin
      v = up ? ((v + 1) & 15) : ((v - 1) & 15);
      e.cyc = first + i * period; e.led = v; e.mode = md;
      tick_q.push_back(e);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("reset_outputs", {led, tick, mode}, 0);
    end
    rst = 1'b1;
  endtask

  task automatic drain(input string nm);
    @(negedge clk);
    #1;
    chk({nm, "_ticks_left"}, tick_q.size(), 0);
    chk({nm, "_modes_left"}, mode_q.size(), 0);
    tick_q.delete();
    mode_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
`ifdef SPEED_RAMP_EN
    // Ramp 00->01->10, retarget to 00 during the 10 dwell
    chk_ticks = 1'b0;
    sw = 2'b00; dir = 1'b1; clr = 1'b0;
    do_reset(4);
    push_mode(17, 1); push_mode(117, 2); push_mode(217, 1); push_mode(317, 0);
    go(10);  sw = 2'b11;
    go(150); sw = 2'b00;
    go(330);
    drain("ramp");
    chk_ticks = 1'b1;
`else
    // 1: reset with sw=11 held, then fast counting
    sw = 2'b11; dir = 1'b1; clr = 1'b0;
    do_reset(10);
    push_mode(7, 3);
    push_ticks(8, 1, 5, 0, 1'b1, 3);
    go(1);
    chk("release_led", led, 0);
    chk("release_mode", mode, 0);
    go(12);
    drain("t1");

    // 2: slow mode, 49 ticks by cycle 1000
    sw = 2'b01;
    do_reset(3);
    push_mode(7, 1);
    push_ticks(27, 20, 49, 0, 1'b1, 1);
    go(1000);
    chk("slow_led", led, 1);
    drain("t2");

    // 3: medium mode, then fast and down across the wrap
    sw = 2'b10;
    do_reset(3);
    push_mode(7, 2);
    push_ticks(9, 2, 50, 0, 1'b1, 2);
    push_ticks(109, 2, 1, 2, 1'b1, 2);
    push_ticks(111, 2, 2, 3, 1'b0, 2);
    push_mode(115, 3);
    push_ticks(115, 1, 6, 1, 1'b0, 3);
    go(107);
    chk("med_led", led, 2);
    go(108);
    sw = 2'b11; dir = 1'b0;
    go(120);
    drain("t3");

    // 4: 3-cycle glitch rejected, 5-cycle pulse accepted
    sw = 2'b00; dir = 1'b1;
    do_reset(3);
    go(10); sw = 2'b01;
    go(13); sw = 2'b00;
    go(40);
    chk("glitch_mode", mode, 0);
    chk("glitch_led", led, 0);
    push_mode(57, 1);
    push_mode(62, 0);
    go(50); sw = 2'b01;
    go(55); sw = 2'b00;
    go(70);
    drain("t4");

    // 5: clear has priority over ticks
    sw = 2'b11; dir = 1'b1;
    do_reset(3);
    push_mode(7, 3);
    push_ticks(8, 1, 15, 0, 1'b1, 3);
    push_ticks(33, 1, 8, 0, 1'b1, 3);
    go(20);
    clr = 1'b1;
    for (int c = 21; c <= 40; c++) begin
      go(c);
      if (c == 30) clr = 1'b0;
      if (c >= 23 && c <= 32) chk("clr_hold", {led, tick}, 0);
    end
    drain("t5");
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
